// File: rtl/config_pkg.sv
// Architecture configuration shared by the memory-side blocks.
package config_pkg;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned PA_BITS = 32;
endpackage

// File: rtl/ahb_ram_loader.sv
// AHB-Lite manager that packs a byte stream into XLEN words and writes them,
// one non-pipelined NONSEQ transfer at a time, to incrementing addresses.
module ahb_ram_loader
   import config_pkg::*;
#(
   parameter logic [PA_BITS-1:0] BASE_ADDR = 'h8000_0000,
   parameter int unsigned        MAX_BYTES = 65536
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 Start,
   input  logic [7:0]           ByteIn,
   input  logic                 ByteValid,
   input  logic                 Last,
   output logic                 ByteReady,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Error,
   output logic [31:0]          ByteCount,
   output logic [PA_BITS-1:0]   HADDR,
   output logic                 HWRITE,
   output logic [1:0]           HTRANS,
   output logic [2:0]           HSIZE,
   output logic [2:0]           HBURST,
   output logic [XLEN-1:0]      HWDATA,
   output logic [XLEN/8-1:0]    HWSTRB,
   input  logic                 HREADY,
   input  logic                 HRESP
);

   localparam int unsigned Lanes = XLEN / 8;
   localparam int unsigned IdxW  = $clog2(Lanes);

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StAddr,
      StData,
      StDone,
      StErr
   } state_e;

   state_e             r_state;
   state_e             w_state_d;
   logic [PA_BITS-1:0] r_addr;
   logic [XLEN-1:0]    r_buf;
   logic [Lanes-1:0]   r_strb;
   logic [IdxW-1:0]    r_idx;
   logic [31:0]        r_count;
   logic               r_last;

   logic w_start;
   logic w_accept;
   logic w_lane_full;
   logic w_complete;

   assign w_start     = Start && (r_state == StIdle || r_state == StDone || r_state == StErr);
   assign w_accept    = (r_state == StFill) && ByteValid;
   assign w_lane_full = (r_idx == IdxW'(Lanes - 1));
   assign w_complete  = (r_state == StData) && HREADY;

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle, StDone, StErr: begin
            if (Start) w_state_d = StFill;
         end
         StFill: begin
            if (w_accept && (w_lane_full || Last)) w_state_d = StAddr;
         end
         StAddr: begin
            if (HREADY) w_state_d = StData;
         end
         StData: begin
            if (HREADY) begin
               if (HRESP)                            w_state_d = StErr;
               else if (r_last)                      w_state_d = StDone;
               else if (r_count == 32'(MAX_BYTES))   w_state_d = StErr;
               else                                  w_state_d = StFill;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_addr  <= '0;
         r_buf   <= '0;
         r_strb  <= '0;
         r_idx   <= '0;
         r_count <= '0;
         r_last  <= 1'b0;
      end else if (w_start) begin
         r_addr  <= BASE_ADDR;
         r_buf   <= '0;
         r_strb  <= '0;
         r_idx   <= '0;
         r_count <= '0;
         r_last  <= 1'b0;
      end else if (w_accept) begin
         for (int l = 0; l < int'(Lanes); l++) begin
            if (r_idx == IdxW'(l)) begin
               r_buf[l*8 +: 8] <= ByteIn;
               r_strb[l]       <= 1'b1;
            end
         end
         r_idx   <= r_idx + 1'b1;
         r_count <= r_count + 32'd1;
         if (Last) r_last <= 1'b1;
      end else if (w_complete && !HRESP) begin
         // A failed write leaves the address on the faulting word.
         r_addr <= r_addr + PA_BITS'(Lanes);
         r_buf  <= '0;
         r_strb <= '0;
         r_idx  <= '0;
      end
   end

   assign ByteReady = (r_state == StFill);
   assign Busy      = (r_state == StFill) || (r_state == StAddr) || (r_state == StData);
   assign Done      = (r_state == StDone);
   assign Error     = (r_state == StErr);
   assign ByteCount = r_count;
   assign HADDR     = r_addr;
   assign HWRITE    = (r_state == StAddr);
   assign HTRANS    = (r_state == StAddr) ? 2'b10 : 2'b00;
   assign HSIZE     = 3'($clog2(Lanes));
   assign HBURST    = 3'b000;
   assign HWDATA    = (r_state == StData) ? r_buf : '0;
   assign HWSTRB    = (r_state == StData) ? r_strb : '0;

endmodule

// File: tb/tb_ahb_ram_loader.sv
// Randomised bench for ahb_ram_loader: writes observed on the bus are compared
// against words computed directly from the byte image.
module tb_ahb_ram_loader;

   localparam logic [31:0] Base = 32'h8000_0000;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        Start = 1'b0;
   logic [7:0]  ByteIn = 8'h00;
   logic        ByteValid = 1'b0;
   logic        Last = 1'b0;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;

   logic        ByteReady, Busy, Done, Error, HWRITE;
   logic [31:0] ByteCount, HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic [63:0] HWDATA;
   logic [7:0]  HWSTRB;

   logic        sm_ByteReady, sm_Busy, sm_Done, sm_Error, sm_HWRITE;
   logic [31:0] sm_ByteCount, sm_HADDR;
   logic [1:0]  sm_HTRANS;
   logic [2:0]  sm_HSIZE, sm_HBURST;
   logic [63:0] sm_HWDATA;
   logic [7:0]  sm_HWSTRB;

   int n_checks = 0;
   int n_fail = 0;
   int hr_mode = 0;   // 0: HREADY=1, 1: random, 2: driven by the test

   logic [31:0] mon_addr[$];
   logic [63:0] mon_data[$];
   logic [7:0]  mon_strb[$];
   int          mon_alen[$];
   int          ready_viol = 0;
   int          sm_nw = 0;
   logic [31:0] sm_last_addr = '0;

   always #5 HCLK = ~HCLK;

   ahb_ram_loader #(.BASE_ADDR(Base), .MAX_BYTES(65536)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .Start(Start), .ByteIn(ByteIn),
      .ByteValid(ByteValid), .Last(Last), .ByteReady(ByteReady), .Busy(Busy),
      .Done(Done), .Error(Error), .ByteCount(ByteCount), .HADDR(HADDR),
      .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
      .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(HREADY), .HRESP(HRESP)
   );

   ahb_ram_loader #(.BASE_ADDR(Base), .MAX_BYTES(16)) u_small (
      .HCLK(HCLK), .HRESETn(HRESETn), .Start(Start), .ByteIn(ByteIn),
      .ByteValid(ByteValid), .Last(Last), .ByteReady(sm_ByteReady), .Busy(sm_Busy),
      .Done(sm_Done), .Error(sm_Error), .ByteCount(sm_ByteCount), .HADDR(sm_HADDR),
      .HWRITE(sm_HWRITE), .HTRANS(sm_HTRANS), .HSIZE(sm_HSIZE), .HBURST(sm_HBURST),
      .HWDATA(sm_HWDATA), .HWSTRB(sm_HWSTRB), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial begin
      forever begin
         @(posedge HCLK);
         #1;
         if (hr_mode == 0) HREADY = 1'b1;
         else if (hr_mode == 1) HREADY = ($urandom_range(0, 2) != 0);
      end
   end

   // Bus monitor: samples mid-cycle, so values seen here are what the next edge uses.
   initial begin
      bit dph;
      int alen;
      dph = 0;
      alen = 0;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            dph = 0;
            alen = 0;
         end else begin
            if (ByteReady && (HTRANS != 2'b00 || dph)) ready_viol++;
            if (dph && HREADY) begin
               mon_data.push_back(HWDATA);
               mon_strb.push_back(HWSTRB);
               dph = 0;
            end
            if (HTRANS == 2'b10) begin
               alen++;
               if (HREADY) begin
                  mon_addr.push_back(HADDR);
                  mon_alen.push_back(alen);
                  alen = 0;
                  dph = 1;
               end
            end
            if (sm_HTRANS == 2'b10 && HREADY) begin
               sm_nw++;
               sm_last_addr = sm_HADDR;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic mon_clear();
      mon_addr.delete();
      mon_data.delete();
      mon_strb.delete();
      mon_alen.delete();
      ready_viol = 0;
   endtask

   task automatic do_start();
      Start = 1'b1;
      @(posedge HCLK);
      #1;
      Start = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] img[$], input bit use_small, input bit rnd,
                             input int limit, output int sent);
      int cyc;
      bit v;
      logic rdy;
      sent = 0;
      cyc = 0;
      while (sent < img.size() && cyc < limit) begin
         v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         ByteValid = v;
         ByteIn = v ? img[sent] : 8'($urandom);
         Last = v ? (sent == img.size() - 1) : 1'($urandom);
         rdy = use_small ? sm_ByteReady : ByteReady;
         if (v && rdy) sent++;
         @(posedge HCLK);
         #1;
         cyc++;
      end
      ByteValid = 1'b0;
      Last = 1'b0;
   endtask

   task automatic wait_end(input bit use_small, input int limit, output bit ok);
      int cyc;
      cyc = 0;
      while (!(use_small ? (sm_Done || sm_Error) : (Done || Error)) && cyc < limit) begin
         @(posedge HCLK);
         #1;
         cyc++;
      end
      ok = use_small ? (sm_Done || sm_Error) : (Done || Error);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge HCLK);
      #1;
      n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
      n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
      n_checks++; if (Done !== 1'b0 || Error !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b want 00", Done, Error); end
      n_checks++; if (ByteCount !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", ByteCount); end
      n_checks++; if (ByteReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ByteReady); end
      n_checks++; if (HWRITE !== 1'b0 || HADDR !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %b/%h want 0/0", HWRITE, HADDR); end
      n_checks++; if (HWDATA !== 64'd0 || HWSTRB !== 8'd0) begin n_fail++; $display("FAIL reset_wdata: got %h/%h want 0/0", HWDATA, HWSTRB); end
      n_checks++; if (HBURST !== 3'b000) begin n_fail++; $display("FAIL reset_hburst: got %b want 000", HBURST); end
   endtask

   task automatic test_two_words();
      logic [7:0] img[$];
      int sent;
      bit ok;
      for (int i = 0; i < 16; i++) img.push_back(8'(i));
      hr_mode = 0;
      mon_clear();
      do_start();
      send_bytes(img, 0, 1, 500, sent);
      wait_end(0, 50, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL two_timeout: Done/Error never set"); end
      n_checks++; if (mon_data.size() !== 2) begin n_fail++; $display("FAIL two_nwrites: got %0d want 2", mon_data.size()); end
      if (mon_data.size() == 2 && mon_addr.size() == 2) begin
         n_checks++; if (mon_addr[0] !== 32'h8000_0000 || mon_data[0] !== 64'h0706050403020100 || mon_strb[0] !== 8'hFF) begin
            n_fail++; $display("FAIL two_w0: got %h/%h/%h want 80000000/0706050403020100/ff", mon_addr[0], mon_data[0], mon_strb[0]); end
         n_checks++; if (mon_addr[1] !== 32'h8000_0008 || mon_data[1] !== 64'h0F0E0D0C0B0A0908 || mon_strb[1] !== 8'hFF) begin
            n_fail++; $display("FAIL two_w1: got %h/%h/%h want 80000008/0f0e0d0c0b0a0908/ff", mon_addr[1], mon_data[1], mon_strb[1]); end
         n_checks++; if (mon_alen[0] !== 1 || mon_alen[1] !== 1) begin
            n_fail++; $display("FAIL two_alen: got %0d,%0d want 1,1", mon_alen[0], mon_alen[1]); end
      end
      n_checks++; if (Done !== 1'b1 || ByteCount !== 32'd16) begin n_fail++; $display("FAIL two_done: got %b/%0d want 1/16", Done, ByteCount); end
   endtask

   task automatic test_partial();
      logic [7:0] img[$];
      int sent;
      bit ok;
      img = '{8'hAA, 8'hBB, 8'hCC};
      mon_clear();
      do_start();
      send_bytes(img, 0, 1, 200, sent);
      wait_end(0, 50, ok);
      n_checks++; if (!ok || mon_data.size() !== 1) begin n_fail++; $display("FAIL part_nwrites: got %0d want 1", mon_data.size()); end
      if (mon_data.size() == 1) begin
         n_checks++; if (mon_addr[0] !== Base || mon_data[0] !== 64'h0000000000CCBBAA || mon_strb[0] !== 8'h07) begin
            n_fail++; $display("FAIL part_w0: got %h/%h/%h want 80000000/0000000000ccbbaa/07", mon_addr[0], mon_data[0], mon_strb[0]); end
      end
      n_checks++; if (Done !== 1'b1 || ByteCount !== 32'd3) begin n_fail++; $display("FAIL part_done: got %b/%0d want 1/3", Done, ByteCount); end
   endtask

   task automatic test_stall();
      logic [7:0] img[$];
      logic [63:0] exp_d;
      int sent;
      for (int i = 0; i < 8; i++) begin
         img.push_back(8'($urandom));
         exp_d[8*i +: 8] = img[i];
      end
      hr_mode = 2;
      HREADY = 1'b0;
      mon_clear();
      do_start();
      send_bytes(img, 0, 0, 20, sent);
      for (int c = 0; c < 3; c++) begin
         n_checks++; if (HTRANS !== 2'b10 || HADDR !== Base || HWRITE !== 1'b1 || ByteReady !== 1'b0) begin
            n_fail++; $display("FAIL stall_addr%0d: got %b/%h/%b/%b want 10/%h/1/0", c, HTRANS, HADDR, HWRITE, ByteReady, Base); end
         @(posedge HCLK);
         #1;
      end
      n_checks++; if (HSIZE !== 3'd3 || HBURST !== 3'd0) begin n_fail++; $display("FAIL stall_size: got %0d/%0d want 3/0", HSIZE, HBURST); end
      HREADY = 1'b1;
      @(posedge HCLK);
      #1;
      HREADY = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_checks++; if (HTRANS !== 2'b00 || HWDATA !== exp_d || HWSTRB !== 8'hFF || ByteReady !== 1'b0) begin
            n_fail++; $display("FAIL stall_data%0d: got %b/%h/%h/%b want 00/%h/ff/0", c, HTRANS, HWDATA, HWSTRB, ByteReady, exp_d); end
         @(posedge HCLK);
         #1;
      end
      HREADY = 1'b1;
      @(posedge HCLK);
      #1;
      repeat (2) @(posedge HCLK);
      #1;
      n_checks++; if (Done !== 1'b1 || mon_data.size() !== 1) begin n_fail++; $display("FAIL stall_once: got done=%b writes=%0d want 1/1", Done, mon_data.size()); end
      if (mon_data.size() == 1) begin
         n_checks++; if (mon_data[0] !== exp_d || mon_alen[0] !== 4) begin
            n_fail++; $display("FAIL stall_w0: got %h/alen %0d want %h/4", mon_data[0], mon_alen[0], exp_d); end
      end
      n_checks++; if (ready_viol !== 0) begin n_fail++; $display("FAIL stall_ready: got %0d want 0", ready_viol); end
      hr_mode = 0;
   endtask

   task automatic test_error();
      logic [7:0] img[$];
      int sent;
      bit ok;
      for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
      hr_mode = 0;
      HRESP = 1'b1;
      mon_clear();
      do_start();
      send_bytes(img, 0, 1, 150, sent);
      wait_end(0, 50, ok);
      HRESP = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      n_checks++; if (Error !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL err_flag: got err=%b done=%b want 1/0", Error, Done); end
      n_checks++; if (HTRANS !== 2'b00 || ByteReady !== 1'b0) begin n_fail++; $display("FAIL err_idle: got %b/%b want 00/0", HTRANS, ByteReady); end
      n_checks++; if (mon_data.size() !== 1 || sent !== 8 || ByteCount !== 32'd8) begin
         n_fail++; $display("FAIL err_count: got writes=%0d sent=%0d cnt=%0d want 1/8/8", mon_data.size(), sent, ByteCount); end
      do_start();
      n_checks++; if (ByteReady !== 1'b1 || Busy !== 1'b1 || HADDR !== Base) begin
         n_fail++; $display("FAIL err_restart: got %b/%b/%h want 1/1/%h", ByteReady, Busy, HADDR, Base); end
      img = '{8'h11, 8'h22};
      mon_clear();
      send_bytes(img, 0, 1, 100, sent);
      wait_end(0, 50, ok);
      n_checks++; if (!Done || mon_addr.size() !== 1 || mon_addr[0] !== Base) begin
         n_fail++; $display("FAIL err_reload: got done=%b writes=%0d want 1/1 at %h", Done, mon_addr.size(), Base); end
   endtask

   task automatic test_random();
      logic [7:0] img[$];
      logic [63:0] exp_d;
      logic [7:0] exp_s;
      int len, nw, sent;
      bit ok;
      hr_mode = 1;
      for (int it = 0; it < 6; it++) begin
         img.delete();
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) img.push_back(8'($urandom));
         nw = (len + 7) / 8;
         mon_clear();
         do_start();
         send_bytes(img, 0, 1, 3000, sent);
         wait_end(0, 300, ok);
         n_checks++; if (!ok || Done !== 1'b1 || ByteCount !== 32'(len)) begin
            n_fail++; $display("FAIL rnd%0d_done: got done=%b cnt=%0d want 1/%0d", it, Done, ByteCount, len); end
         n_checks++; if (mon_data.size() !== nw || mon_addr.size() !== nw) begin
            n_fail++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, mon_data.size(), nw); end
         for (int k = 0; k < nw && k < mon_data.size(); k++) begin
            exp_d = '0;
            exp_s = '0;
            for (int j = 0; j < 8; j++) begin
               if (8 * k + j < len) begin
                  exp_d[8*j +: 8] = img[8*k + j];
                  exp_s[j] = 1'b1;
               end
            end
            n_checks++; if (mon_addr[k] !== Base + 32'(8 * k) || mon_data[k] !== exp_d || mon_strb[k] !== exp_s) begin
               n_fail++; $display("FAIL rnd%0d_w%0d: got %h/%h/%h want %h/%h/%h", it, k,
                                  mon_addr[k], mon_data[k], mon_strb[k], Base + 32'(8 * k), exp_d, exp_s); end
         end
         n_checks++; if (ready_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_ready: got %0d want 0", it, ready_viol); end
      end
      hr_mode = 0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] img[$];
      int sent;
      for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
      hr_mode = 2;
      HREADY = 1'b1;
      mon_clear();
      do_start();
      send_bytes(img, 0, 0, 20, sent);
      @(posedge HCLK);
      #1;
      HREADY = 1'b0;
      n_checks++; if (HWSTRB !== 8'hFF) begin n_fail++; $display("FAIL rmid_indata: got strb %h want ff", HWSTRB); end
      #2;
      HRESETn = 1'b0;
      #1;
      n_checks++; if (HTRANS !== 2'b00 || Busy !== 1'b0 || ByteCount !== 32'd0 || HWSTRB !== 8'h00) begin
         n_fail++; $display("FAIL rmid_async: got %b/%b/%0d/%h want 00/0/0/00", HTRANS, Busy, ByteCount, HWSTRB); end
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      HREADY = 1'b1;
      repeat (3) @(posedge HCLK);
      #1;
      n_checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0 || ByteReady !== 1'b0) begin
         n_fail++; $display("FAIL rmid_idle: got busy=%b done=%b err=%b rdy=%b want 0000", Busy, Done, Error, ByteReady); end
      n_checks++; if (mon_data.size() !== 0) begin n_fail++; $display("FAIL rmid_nowrite: got %0d want 0", mon_data.size()); end
      hr_mode = 0;
   endtask

   task automatic test_overflow();
      logic [7:0] img[$];
      int sent;
      bit ok;
      for (int i = 0; i < 17; i++) img.push_back(8'($urandom));
      hr_mode = 1;
      sm_nw = 0;
      do_start();
      send_bytes(img, 1, 1, 400, sent);
      wait_end(1, 100, ok);
      n_checks++; if (!ok || sm_Error !== 1'b1 || sm_Done !== 1'b0) begin
         n_fail++; $display("FAIL ovf_flag: got err=%b done=%b want 1/0", sm_Error, sm_Done); end
      n_checks++; if (sent !== 16 || sm_ByteCount !== 32'd16 || sm_ByteReady !== 1'b0) begin
         n_fail++; $display("FAIL ovf_count: got sent=%0d cnt=%0d rdy=%b want 16/16/0", sent, sm_ByteCount, sm_ByteReady); end
      n_checks++; if (sm_nw !== 2 || sm_last_addr !== 32'h8000_0008) begin
         n_fail++; $display("FAIL ovf_writes: got %0d last %h want 2 last 80000008", sm_nw, sm_last_addr); end
      hr_mode = 0;
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_partial();
      test_stall();
      test_error();
      test_random();
      test_reset_mid();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_ram_loader.md
Name: ahb_ram_loader

Overview:
- AHB-Lite manager that sits directly upstream of the on-chip RAM subordinate and preloads it from a byte stream, such as a UART or JTAG debug loader.
- Packs incoming bytes little-endian into XLEN words and issues single NONSEQ word writes to incrementing addresses starting at BASE_ADDR.
- Handles subordinate wait states (HREADY low) and error responses.
- Has one outstanding transfer at a time, with no address/data pipelining.

Parameters:
- BASE_ADDR, 'h80000000: first write address; must be XLEN/8-aligned.
- MAX_BYTES, 65536: load-window size in bytes; multiple of XLEN/8.
- XLEN and PA_BITS are taken from config_pkg.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- Start  in  1  begin a load; ignored unless in IDLE, DONE or ERR.
- ByteIn  in  8  stream data.
- ByteValid  in  1  stream valid.
- Last  in  1  qualifies the final byte of the image.
- ByteReady  out  1  stream ready.
- Busy  out  1  high in FILL/ADDR/DATA.
- Done  out  1  high in DONE.
- Error  out  1  high in ERR.
- ByteCount  out  32  bytes accepted since Start.
- HADDR  out  PA_BITS  transfer address.
- HWRITE  out  1  write flag.
- HTRANS  out  2  transfer type.
- HSIZE  out  3  transfer size.
- HBURST  out  3  burst type.
- HWDATA  out  XLEN  write data.
- HWSTRB  out  XLEN/8  byte strobes.
- HREADY  in  1  transfer-complete / ready.
- HRESP  in  1  error response.

Behaviour:
- Reset (async, HRESETn=0): state IDLE; all outputs 0; HTRANS=2'b00.
- Fixed AHB outputs: HSIZE=log2(XLEN/8) always; HBURST=3'b000 always.
- State IDLE: Start goes to FILL. At that transition, ByteCount, lane index and word buffer clear, and the address register loads BASE_ADDR.
- State FILL: ByteReady=1.
  - Each accepted byte (ByteValid&ByteReady) goes into lane[idx], sets strobe bit idx, increments idx and ByteCount.
  - The transition to ADDR occurs on the cycle after a byte is accepted when either:
    - that byte filled lane XLEN/8-1, or
    - that byte had Last=1.
  - ByteReady=0 from that point until the next FILL.
- State ADDR: HTRANS=2'b10, HWRITE=1, HADDR=address register.
  - HTRANS/HADDR/HWRITE are held stable while HREADY=0.
  - At a rising edge with HREADY=1, go to DATA.
- State DATA: HTRANS=2'b00; HWDATA = packed word; HWSTRB = accumulated strobes. Unfilled lanes are 0.
  - Both values are held stable until a rising edge with HREADY=1.
  - On completion with HRESP=1: go to ERR.
  - On completion with HRESP=0, the address advances by XLEN/8, the buffer, strobes and idx clear, and the next state is chosen as follows:
    - the word included Last: DONE;
    - otherwise, ByteCount==MAX_BYTES: ERR (overflow);
    - otherwise: FILL.
- State DONE / state ERR: outputs held until Start, which goes to FILL with the same clearing as from IDLE. ByteCount is frozen (readable).
- Partial final word: strobes cover only the filled lanes; address stays word-aligned.
- Wait-state latency: per full word, XLEN/8 FILL cycles + 1 ADDR + 1 DATA cycle when HREADY=1. Each HREADY=0 cycle adds one cycle.
- Byte handling:
  - ByteValid while ByteReady=0: no byte consumed; producer must hold.
  - Last asserted with ByteValid=0: ignored.
- Start while Busy: ignored.
- Reset mid-transfer: immediate return to reset values; no completion is signalled.

Test Plan (XLEN=64, BASE_ADDR='h80000000):
- Start, bytes 0x00..0x0F (Last on 0x0F), HREADY=1 -> writes:
  - 0x80000000 / 0x0706050403020100 / strb 0xFF;
  - 0x80000008 / 0x0F0E0D0C0B0A0908 / strb 0xFF;
  - then Done=1, ByteCount=16, each address phase exactly 1 cycle.
- Start, bytes 0xAA,0xBB,0xCC (Last on 0xCC) -> one write to 0x80000000, HWDATA=0x0000000000CCBBAA, HWSTRB=0x07, Done=1, ByteCount=3.
- HREADY=0 for 3 cycles during ADDR, then 2 cycles during DATA -> HADDR/HTRANS=2'b10 stable across the ADDR stall, HWDATA/HWSTRB stable across the DATA stall, ByteReady=0 throughout, write completes exactly once.
- HRESP=1 at first DATA completion -> Error=1, HTRANS=2'b00, ByteReady=0, no second write; later Start -> FILL, address back to 0x80000000.
- MAX_BYTES=16, 17 bytes with Last on the 17th -> after the write to 0x80000008 completes, Error=1; the 17th byte is never accepted.
- HRESETn pulsed low mid-DATA -> same cycle HTRANS=0, Busy=0, ByteCount=0; after release, state IDLE until Start.
